// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory-side blocks.
//   mem_state_t     : responder sequencing states
//   DEFAULT_IO_ADDR : address of the switch/hex I/O word
//   byte_merge      : byte-enable merge of a new word into an old one
package lc3b_types;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      RESP
   } mem_state_t;

   localparam logic [19:0] DEFAULT_IO_ADDR = 20'hFFFFF;

   // be[1] selects the upper byte, be[0] the lower byte.
   function automatic logic [15:0] byte_merge(input logic [15:0] old_w,
                                              input logic [15:0] new_w,
                                              input logic [1:0]  be);
      byte_merge[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
      byte_merge[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
   endfunction

endpackage

// File: rtl/tri_buff.sv
// Tri-state bus driver with read-back.
//   en   : drive din onto bus when high, release (Z) otherwise
//   din  : value to drive
//   dout : whatever is currently on the bus
//   bus  : the shared bidirectional bus
module tri_buff #(
   parameter int W = 16
) (
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   inout  wire  [W-1:0] bus
);

   assign bus  = en ? din : {W{1'bz}};
   assign dout = bus;

endmodule

// File: rtl/mem_responder.sv
// Target-side memory responder: accepts one read/write at a time from the
// CPU bus, sequences async SRAM strobes over WAIT_STATES cycles, returns
// read data on Data and pulses mem_resp. One address (IO_ADDR) is an I/O
// word: reads return Switches, writes update hex_out.
//   Clk, Reset            : clock, synchronous active-high reset
//   ADDR, Data            : request address, shared bidirectional data bus
//   mem_read, mem_write   : level request strobes (read wins if both high)
//   mem_byte_en           : write byte enables ([1] upper, [0] lower)
//   mem_resp              : one-cycle completion pulse
//   Switches, hex_out     : I/O word read source / write target
//   sram_*                : async SRAM address, data and active-low strobes
module mem_responder
   import lc3b_types::*;
#(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [19:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [19:0] ADDR,
   inout  wire  [15:0] Data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_en,
   output logic        mem_resp,
   input  logic [15:0] Switches,
   output logic [15:0] hex_out,
   output logic [19:0] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   // Counter is loaded with WAIT_STATES-1 and the state leaves on zero,
   // so a wait state occupies exactly WAIT_STATES cycles.
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

   mem_state_t  state;
   logic [3:0]  wait_cnt;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        data_oe;     // drive Data with rdata (read RESP only)
   logic        sram_oe;     // drive sram_data with wdata (write wait + RESP)
   logic [15:0] data_in;
   logic [15:0] sram_in;
   logic        req;
   logic        is_io;

   assign req   = mem_read | mem_write;
   assign is_io = (ADDR == IO_ADDR);

   tri_buff #(.W(16)) u_data_buf (
      .en   (data_oe),
      .din  (rdata),
      .dout (data_in),
      .bus  (Data)
   );

   tri_buff #(.W(16)) u_sram_buf (
      .en   (sram_oe),
      .din  (wdata),
      .dout (sram_in),
      .bus  (sram_data)
   );

   // Strobes are registered and set on the edge that enters each state, so
   // they always line up with the state they belong to.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         wdata     <= '0;
         rdata     <= '0;
         data_oe   <= 1'b0;
         sram_oe   <= 1'b0;
         mem_resp  <= 1'b0;
         hex_out   <= '0;
         sram_addr <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_lb_n <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  sram_addr <= ADDR;
                  wait_cnt  <= WAIT_INIT;
                  // Data is only valid from the initiator on writes.
                  if (!mem_read) wdata <= data_in;
                  if (is_io) begin
                     // I/O word completes without touching the SRAM.
                     state    <= RESP;
                     mem_resp <= 1'b1;
                     if (mem_read) begin
                        rdata   <= Switches;
                        data_oe <= 1'b1;
                     end else begin
                        hex_out <= byte_merge(hex_out, data_in, mem_byte_en);
                     end
                  end else if (mem_read) begin
                     state     <= READ_WAIT;
                     sram_ce_n <= 1'b0;
                     sram_oe_n <= 1'b0;
                     sram_ub_n <= 1'b0;
                     sram_lb_n <= 1'b0;
                  end else begin
                     state     <= WRITE_WAIT;
                     sram_oe   <= 1'b1;
                     sram_ce_n <= 1'b0;
                     sram_we_n <= 1'b0;
                     sram_ub_n <= ~mem_byte_en[1];
                     sram_lb_n <= ~mem_byte_en[0];
                  end
               end
            end

            READ_WAIT: begin
               if (wait_cnt == '0) begin
                  rdata     <= sram_in;
                  data_oe   <= 1'b1;
                  state     <= RESP;
                  mem_resp  <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_ub_n <= 1'b1;
                  sram_lb_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            WRITE_WAIT: begin
               // sram_oe stays set into RESP so data holds past we_n rising.
               if (wait_cnt == '0) begin
                  state     <= RESP;
                  mem_resp  <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  sram_ub_n <= 1'b1;
                  sram_lb_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            RESP: begin
               state    <= IDLE;
               mem_resp <= 1'b0;
               data_oe  <= 1'b0;
               sram_oe  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// randomized transactions, checked cycle by cycle against expectations
// derived from transaction rules and a shadow memory.
module tb_mem_responder;

   localparam int          W  = 2;
   localparam logic [19:0] IO = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        Reset;
   logic [19:0] ADDR;
   wire  [15:0] Data;
   logic        mem_read, mem_write;
   logic [1:0]  mem_byte_en;
   logic        mem_resp;
   logic [15:0] Switches;
   logic [15:0] hex_out;
   logic [19:0] sram_addr;
   wire  [15:0] sram_data;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   logic [15:0] tb_data;
   logic        tb_data_en;
   assign Data = tb_data_en ? tb_data : 16'hzzzz;

   always #5 clk = ~clk;

   mem_responder #(.WAIT_STATES(W), .IO_ADDR(IO)) dut (
      .Clk(clk), .Reset(Reset), .ADDR(ADDR), .Data(Data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
      .mem_resp(mem_resp), .Switches(Switches), .hex_out(hex_out),
      .sram_addr(sram_addr), .sram_data(sram_data),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   // ---------------- async SRAM environment model ----------------
   logic [15:0] mem_arr [0:1023];
   logic        init_req;

   function automatic logic [15:0] init_word(input int i);
      return (i == 'h123) ? 16'hBEEF : (16'hC300 ^ 16'(i));
   endfunction

   assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n)
                      ? mem_arr[sram_addr[9:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
      end else if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem_arr[sram_addr[9:0]][7:0]  <= sram_data[7:0];
         if (!sram_ub_n) mem_arr[sram_addr[9:0]][15:8] <= sram_data[15:8];
      end
   end

   // ---------------- reference model state ----------------
   logic [15:0] ref_mem [0:1023];
   logic [15:0] hex_m;

   function automatic logic [15:0] m_merge(input logic [15:0] o, input logic [15:0] n,
                                           input logic [1:0] be);
      logic [15:0] r;
      r = o;
      if (be[0]) r[7:0]  = n[7:0];
      if (be[1]) r[15:8] = n[15:8];
      return r;
   endfunction

   // Expected outputs for the current cycle.
   logic        e_resp, e_ce, e_oe, e_we, e_ub, e_lb;
   bit          e_lanes, e_addr_chk, e_data_chk;
   logic [19:0] e_addr;
   logic [15:0] e_data, e_sd;
   bit          chk_en;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          resp_cnt = 0;
   logic [15:0] last_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_resp", 32'(mem_resp), 32'(e_resp));
         chk("sram_ce_n", 32'(sram_ce_n), 32'(e_ce));
         chk("sram_oe_n", 32'(sram_oe_n), 32'(e_oe));
         chk("sram_we_n", 32'(sram_we_n), 32'(e_we));
         if (e_lanes) begin
            chk("sram_ub_n", 32'(sram_ub_n), 32'(e_ub));
            chk("sram_lb_n", 32'(sram_lb_n), 32'(e_lb));
         end
         if (e_addr_chk) chk("sram_addr", 32'(sram_addr), 32'(e_addr));
         if (e_data_chk) chk("Data", 32'(Data), 32'(e_data));
         chk("sram_data", 32'(sram_data), 32'(e_sd));
         chk("hex_out", 32'(hex_out), 32'(hex_m));
         if (mem_resp === 1'b1) begin
            resp_cnt <= resp_cnt + 1;
            last_rd  <= Data;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      e_resp = 0; e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1;
      e_lanes = 1; e_addr_chk = 0;
      e_data_chk = !tb_data_en; e_data = 16'hzzzz;
      e_sd = 16'hzzzz;
   endtask

   task automatic set_wait_exp(input bit rd, input logic [19:0] a, input logic [15:0] d,
                               input logic [1:0] be);
      e_resp = 0; e_ce = 0; e_lanes = 1; e_addr_chk = 1; e_addr = a;
      if (rd) begin
         e_oe = 0; e_we = 1; e_ub = 0; e_lb = 0;
         e_data_chk = 1; e_data = 16'hzzzz; e_sd = ref_mem[a[9:0]];
      end else begin
         e_oe = 1; e_we = 0; e_ub = ~be[1]; e_lb = ~be[0];
         e_data_chk = 0; e_sd = d;
      end
   endtask

   task automatic scramble(input bit rd);
      ADDR        = 20'($urandom);
      mem_byte_en = 2'($urandom);
      Switches    = 16'($urandom);
      if (!rd) tb_data = 16'($urandom);
   endtask

   // One transaction, starting in the IDLE cycle where the request is first
   // presented and ending just after the edge that leaves RESP. Requests are
   // left asserted; the caller decides whether the next cycle is idle.
   task automatic do_txn(input bit rd, input bit wr, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] be, input logic [15:0] sw);
      bit io;
      io = (a == IO);
      mem_read = rd; mem_write = wr; ADDR = a; mem_byte_en = be; Switches = sw;
      tb_data_en = !rd; tb_data = d;
      set_idle_exp();
      cyc();                                   // E0: accepted
      if (io && !rd) hex_m = m_merge(hex_m, d, be);
      scramble(rd);
      if (!io) begin
         for (int k = 0; k < W; k++) begin
            set_wait_exp(rd, a, d, be);
            cyc();
            scramble(rd);
         end
      end
      e_resp = 1; e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1;
      e_lanes = io; e_addr_chk = !io; e_addr = a;
      e_data_chk = rd;
      e_data = io ? sw : ref_mem[a[9:0]];
      e_sd = (!rd && !io) ? d : 16'hzzzz;
      cyc();                                   // leaves RESP
      if (!rd && !io) ref_mem[a[9:0]] = m_merge(ref_mem[a[9:0]], d, be);
   endtask

   task automatic idle(input int n);
      mem_read = 0; mem_write = 0; tb_data_en = 0;
      for (int k = 0; k < n; k++) begin
         set_idle_exp();
         cyc();
      end
   endtask

   int rc;

   initial begin
      Reset = 1; mem_read = 0; mem_write = 0; ADDR = '0; mem_byte_en = '0;
      Switches = '0; tb_data = '0; tb_data_en = 0; init_req = 1; chk_en = 0;
      hex_m = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      set_idle_exp();
      cyc();
      init_req = 0;
      chk_en = 1;                              // reset state is now visible
      cyc();
      Reset = 0;
      idle(2);

      // SRAM read of 0x00123
      rc = resp_cnt;
      do_txn(1, 0, 20'h00123, 16'h0000, 2'b00, 16'h0000);
      idle(1);
      chk("pin_read_beef", 32'(last_rd), 32'h0000BEEF);
      chk("pin_read_pulses", 32'(resp_cnt - rc), 32'd1);

      // byte write: low byte only
      rc = resp_cnt;
      do_txn(0, 1, 20'h00040, 16'h12AB, 2'b01, 16'h0000);
      idle(1);
      chk("pin_byte_write", 32'(mem_arr[10'h040]), 32'h0000C3AB);
      chk("pin_write_pulses", 32'(resp_cnt - rc), 32'd1);

      // I/O write then read
      do_txn(0, 1, IO, 16'h5A5A, 2'b11, 16'h0000);
      idle(1);
      chk("pin_hex", 32'(hex_out), 32'h00005A5A);
      do_txn(1, 0, IO, 16'h0000, 2'b00, 16'h00F3);
      idle(1);
      chk("pin_io_read", 32'(last_rd), 32'h000000F3);

      // simultaneous read+write, held through the response
      rc = resp_cnt;
      do_txn(1, 1, 20'h00123, 16'h1111, 2'b11, 16'h0000);
      do_txn(1, 1, 20'h00123, 16'h1111, 2'b11, 16'h0000);
      idle(1);
      chk("pin_held_pulses", 32'(resp_cnt - rc), 32'd2);
      chk("pin_held_data", 32'(last_rd), 32'h0000BEEF);

      // reset during the first write wait cycle
      rc = resp_cnt;
      mem_write = 1; ADDR = 20'h00200; mem_byte_en = 2'b11;
      tb_data_en = 1; tb_data = 16'h7777;
      set_idle_exp();
      cyc();                                   // E0
      Reset = 1;
      set_wait_exp(0, 20'h00200, 16'h7777, 2'b11);
      cyc();                                   // reset takes effect
      Reset = 0; mem_write = 0; tb_data_en = 0; hex_m = '0;
      idle(3);
      chk("pin_reset_no_resp", 32'(resp_cnt - rc), 32'd0);
      chk("pin_reset_hex", 32'(hex_out), 32'd0);
      do_txn(1, 0, 20'h00123, 16'h0000, 2'b00, 16'h0000);
      idle(1);
      chk("pin_after_reset_read", 32'(last_rd), 32'h0000BEEF);
      do_txn(0, 1, 20'h00200, 16'hA55A, 2'b11, 16'h0000);
      do_txn(1, 0, 20'h00200, 16'h0000, 2'b00, 16'h0000);
      idle(1);
      chk("pin_rewrite_read", 32'(last_rd), 32'h0000A55A);

      // randomized transactions
      for (int t = 0; t < 120; t++) begin
         logic [19:0] a;
         int          kind;
         kind = $urandom_range(0, 2);
         if ($urandom_range(0, 4) == 0) a = IO;
         else if ($urandom_range(0, 3) == 0) a = 20'($urandom);
         else a = 20'($urandom_range(0, 1023));
         do_txn(kind != 1, kind != 0, a, 16'($urandom), 2'($urandom), 16'($urandom));
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
